tc_program_fetch_unit: RTL and testbench

//   Instruction fetch sequencer for the byte-wide program memory (TC_Program8_1 class).
//   - Owns the program counter and drives the memory address.
//   - Assembles INSTR_BYTES consecutive bytes into one instruction word.
//   - Presents the word to the decoder with a valid/ready handshake.
//   - Handles jumps (redirect) and halt. Sits between program memory and decode.

---
 rtl/tc_program_fetch_unit_pkg.sv | 20 ++
 rtl/tc_instr_assembler.sv | 28 ++
 rtl/tc_program_fetch_unit.sv | 108 ++++++++++
 tb/tb_tc_program_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/tc_program_fetch_unit_pkg.sv
// Shared definitions for the program fetch unit: FSM states, default sizes
// and a helper for sizing the byte index.
package tc_program_fetch_unit_pkg;

  localparam int DEF_INSTR_BYTES = 4;
  localparam int DEF_ADDR_W      = 8;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_VALID  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Width of the byte index; a one-byte instruction still gets a 1-bit index
  // so no zero-width vectors appear.
  function automatic int idx_width(input int n_bytes);
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

endpackage

// File: rtl/tc_instr_assembler.sv
// Byte-lane instruction buffer: writes one byte per cycle into the lane
// selected by idx and holds its contents between writes.
module tc_instr_assembler #(
  parameter int INSTR_BYTES = 4,
  parameter int IDX_W       = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [7:0]               byte_in,
  output logic [8*INSTR_BYTES-1:0] instr
);

  logic [8*INSTR_BYTES-1:0] buf_q;

  // Synchronous clear has priority; otherwise write the addressed byte lane.
  always_ff @(posedge clk) begin
    if (clr) begin
      buf_q <= '0;
    end else if (we) begin
      buf_q[int'(idx)*8 +: 8] <= byte_in;
    end
  end

  assign instr = buf_q;

endmodule

// File: rtl/tc_program_fetch_unit.sv
// Instruction fetch sequencer for a byte-wide program memory: owns the PC,
// gathers INSTR_BYTES bytes per instruction, hands the word to decode over a
// valid/ready handshake, and handles jumps and halt.
module tc_program_fetch_unit
  import tc_program_fetch_unit_pkg::*;
#(
  parameter int                 INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int                 ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [7:0]               rom_data,
  output logic [8*INSTR_BYTES-1:0] instr,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     jump_valid,
  input  logic [ADDR_W-1:0]        jump_addr,
  input  logic                     halt_req,
  output logic                     halted
);

  localparam int                IDX_W    = idx_width(INSTR_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(INSTR_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_BYTES);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic              capture_pc;
  logic              byte_we;

  // State, PC, byte index and instruction address registers; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      idx      <= '0;
      instr_pc <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      idx   <= idx_next;
      if (capture_pc) begin
        instr_pc <= pc;
      end
    end
  end

  // Next-state logic: a jump discards any partial or held instruction and
  // overrides a same-cycle accept; halt_req only matters at the accept.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    idx_next   = idx;
    capture_pc = 1'b0;
    byte_we    = 1'b0;
    if (jump_valid) begin
      state_next = ST_FETCH;
      pc_next    = jump_addr;
      idx_next   = '0;
    end else begin
      case (state)
        ST_FETCH: begin
          byte_we = 1'b1;
          if (idx == LAST_IDX) begin
            state_next = ST_VALID;
            capture_pc = 1'b1;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
        ST_VALID: begin
          if (instr_ready) begin
            pc_next    = pc + PC_STEP;
            idx_next   = '0;
            state_next = halt_req ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: begin
          state_next = ST_HALTED;
        end
        default: begin
          state_next = ST_FETCH;
        end
      endcase
    end
  end

  assign rom_addr    = pc + ADDR_W'(idx);
  assign instr_valid = (state == ST_VALID);
  assign halted      = (state == ST_HALTED);

  tc_instr_assembler #(
    .INSTR_BYTES (INSTR_BYTES),
    .IDX_W       (IDX_W)
  ) u_assembler (
    .clk     (clk),
    .clr     (rst),
    .we      (byte_we),
    .idx     (idx),
    .byte_in (rom_data),
    .instr   (instr)
  );

endmodule

// File: tb/tb_tc_program_fetch_unit.sv
// Directed bench for tc_program_fetch_unit with program memory mem[a] = a ^ 8'h5A.
module tb_tc_program_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_valid;
  logic [7:0]  jump_addr;
  logic        halt_req;
  logic        halted;

  int check_count = 0;
  int error_count = 0;
  int lat;

  tc_program_fetch_unit #(
    .INSTR_BYTES (4),
    .ADDR_W      (8),
    .RESET_PC    (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .halt_req    (halt_req),
    .halted      (halted)
  );

  // Combinational program memory model.
  always_comb rom_data = rom_addr ^ 8'h5A;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic jv,
                               input logic [7:0] ja, input logic hr);
    rst         = r;
    instr_ready = rdy;
    jump_valid  = jv;
    jump_addr   = ja;
    halt_req    = hr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for instr_valid; returns the number of edges waited.
  task automatic waitValid(input int limit, output int n);
    n = 0;
    while (!instr_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_instr", instr, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);
    checkOutput("rst_rom_addr", rom_addr, 0);

    // First instruction from reset, ready held high.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("fetch1_rom_addr", rom_addr, 8'h01);
    checkOutput("fetch1_valid", instr_valid, 0);
    waitValid(10, lat);
    checkOutput("first_latency", lat, 3);
    checkOutput("first_instr", instr, 32'h59585B5A);
    checkOutput("first_pc", instr_pc, 8'h00);
    tick();
    checkOutput("accept0_valid", instr_valid, 0);
    checkOutput("accept0_rom_addr", rom_addr, 8'h04);
    waitValid(10, lat);
    checkOutput("second_latency", lat, 4);
    checkOutput("second_instr", instr, 32'h5D5C5F5E);
    checkOutput("second_pc", instr_pc, 8'h04);

    // Hold with ready low: everything stays put.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_valid", instr_valid, 1);
      checkOutput("hold_instr", instr, 32'h5D5C5F5E);
      checkOutput("hold_pc", instr_pc, 8'h04);
      checkOutput("hold_rom_addr", rom_addr, 8'h07);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("accept4_valid", instr_valid, 0);
    checkOutput("accept4_rom_addr", rom_addr, 8'h08);

    // Jump in the middle of a fetch drops the partial instruction.
    tick();
    tick();
    checkOutput("partial_rom_addr", rom_addr, 8'h0A);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h10, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("jump10_rom_addr", rom_addr, 8'h10);
    checkOutput("jump10_valid", instr_valid, 0);
    waitValid(10, lat);
    checkOutput("jump10_latency", lat, 4);
    checkOutput("jump10_instr", instr, 32'h49484B4A);
    checkOutput("jump10_pc", instr_pc, 8'h10);
    tick();
    checkOutput("accept10_rom_addr", rom_addr, 8'h14);

    // Jump near the top of memory: address wraps mid-instruction.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFE, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("wrap_addr0", rom_addr, 8'hFE);
    tick();
    checkOutput("wrap_addr1", rom_addr, 8'hFF);
    tick();
    checkOutput("wrap_addr2", rom_addr, 8'h00);
    tick();
    checkOutput("wrap_addr3", rom_addr, 8'h01);
    tick();
    checkOutput("wrap_valid", instr_valid, 1);
    checkOutput("wrap_instr", instr, 32'h5B5AA5A4);
    checkOutput("wrap_pc", instr_pc, 8'hFE);
    tick();
    waitValid(10, lat);
    checkOutput("wrap_next_latency", lat, 4);
    checkOutput("wrap_next_pc", instr_pc, 8'h02);

    // Jump together with valid&ready: not an accept, fetch goes to the target.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("squash_valid", instr_valid, 0);
    checkOutput("squash_rom_addr", rom_addr, 8'h40);
    waitValid(10, lat);
    checkOutput("squash_latency", lat, 4);
    checkOutput("squash_instr", instr, 32'h19181B1A);
    checkOutput("squash_pc", instr_pc, 8'h40);

    // Halt at accept, then restart with a jump.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_valid", instr_valid, 0);
    checkOutput("halt_rom_addr", rom_addr, 8'h44);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("halt_stay", {halted, instr_valid}, 2'b10);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h20, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("unhalt_halted", halted, 0);
    checkOutput("unhalt_rom_addr", rom_addr, 8'h20);
    waitValid(10, lat);
    checkOutput("unhalt_latency", lat, 4);
    checkOutput("unhalt_instr", instr, 32'h79787B7A);
    checkOutput("unhalt_pc", instr_pc, 8'h20);

    // halt_req without ready is ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("halt_noready", {halted, instr_valid}, 2'b01);

    // Reset while holding a valid instruction.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("rst_mid_valid", instr_valid, 0);
    checkOutput("rst_mid_instr", instr, 0);
    checkOutput("rst_mid_rom_addr", rom_addr, 8'h00);
    checkOutput("rst_mid_pc", instr_pc, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    waitValid(10, lat);
    checkOutput("rst_again_latency", lat, 4);
    checkOutput("rst_again_instr", instr, 32'h59585B5A);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, error_count);
    $finish;
  end

endmodule
